// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_pkg: opcodes, state encoding and control-field codes  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_ADDI  = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_ONE     = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_BR  = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_ADDI_EXEC = 4'd8,
    S_ADDI_WB   = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic       illegal_op;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control_if: instruction/memory status in, datapath control out|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       alu_src_a;
  logic       illegal_op;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, reg_dst, alu_src_a, illegal_op,
           alu_src_b, alu_op, pc_source
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, mem_to_reg, reg_dst, alu_src_a, illegal_op,
           alu_src_b, alu_op, pc_source
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multicycle_control: multicycle MIPS-subset control FSM                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_ONE;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_BR;
        ctrl.alu_op    = ALU_OP_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_R_EXEC;
          OP_ADDI:      next_state = S_ADDI_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default: begin
            ctrl.illegal_op = 1'b1;
            next_state      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        // A load/store opcode that changed under us is abandoned, never written
        if (bus.opcode == OP_LW)      next_state = S_MEM_READ;
        else if (bus.opcode == OP_SW) next_state = S_MEM_WRITE;
        else                          next_state = S_FETCH;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        next_state      = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
        next_state     = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        next_state     = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADDI;
        next_state     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        next_state     = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        next_state         = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        next_state     = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset silences the datapath at once, before the state register has a clock
    if (reset) ctrl = '0;
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_multicycle_control: directed-vector bench for multicycle_control       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write,
  //  mem_to_reg, reg_dst, alu_src_a, illegal_op, alu_src_b, alu_op, pc_source}
  localparam logic [16:0] E_ZERO       = 17'b00000000000_00_00_00;
  localparam logic [16:0] E_FETCH_RDY  = 17'b10010100000_01_00_00;
  localparam logic [16:0] E_FETCH_WAIT = 17'b00010000000_01_00_00;
  localparam logic [16:0] E_DECODE     = 17'b00000000000_11_00_00;
  localparam logic [16:0] E_DECODE_ILL = 17'b00000000001_11_00_00;
  localparam logic [16:0] E_MEM_ADDR   = 17'b00000000010_10_00_00;
  localparam logic [16:0] E_MEM_READ   = 17'b00110000000_00_00_00;
  localparam logic [16:0] E_MEM_WB     = 17'b00000011000_00_00_00;
  localparam logic [16:0] E_MEM_WRITE  = 17'b00101000000_00_00_00;
  localparam logic [16:0] E_R_EXEC     = 17'b00000000010_00_10_00;
  localparam logic [16:0] E_R_WB       = 17'b00000010100_00_00_00;
  localparam logic [16:0] E_ADDI_EXEC  = 17'b00000000010_10_11_00;
  localparam logic [16:0] E_ADDI_WB    = 17'b00000010000_00_00_00;
  localparam logic [16:0] E_BRANCH     = 17'b01000000010_00_01_01;
  localparam logic [16:0] E_JUMP       = 17'b10000000000_00_00_10;
  localparam logic [5:0]  OP_BAD       = 6'b111111;

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [16:0] exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [16:0] obs;
  int          checks;
  int          errors;

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_write, bus.mem_to_reg,
                bus.reg_dst, bus.alu_src_a, bus.illegal_op,
                bus.alu_src_b, bus.alu_op, bus.pc_source};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_J;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      checks++;
      if (obs !== E_ZERO) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got %b expected %b", i, obs, E_ZERO);
      end
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_jump();
    vec_t v [3];
    v = '{{OP_J, 1'b1, E_FETCH_RDY}, {OP_J, 1'b1, E_DECODE}, {OP_J, 1'b1, E_JUMP}};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL jump[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_lw_wait();
    vec_t v [7];
    v = '{{OP_LW, 1'b1, E_FETCH_RDY}, {OP_LW, 1'b0, E_DECODE}, {OP_LW, 1'b0, E_MEM_ADDR},
          {OP_BAD, 1'b0, E_MEM_READ}, {OP_BAD, 1'b0, E_MEM_READ}, {OP_SW, 1'b1, E_MEM_READ},
          {OP_BAD, 1'b1, E_MEM_WB}};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL lw_wait[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_sw();
    vec_t v [4];
    v = '{{OP_SW, 1'b1, E_FETCH_RDY}, {OP_SW, 1'b1, E_DECODE}, {OP_SW, 1'b1, E_MEM_ADDR},
          {OP_SW, 1'b1, E_MEM_WRITE}};
    for (int i = 0; i < 4; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL sw[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_rtype();
    vec_t v [4];
    v = '{{OP_RTYPE, 1'b1, E_FETCH_RDY}, {OP_RTYPE, 1'b0, E_DECODE},
          {OP_LW, 1'b0, E_R_EXEC}, {OP_SW, 1'b0, E_R_WB}};
    for (int i = 0; i < 4; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL rtype[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_addi();
    vec_t v [4];
    v = '{{OP_ADDI, 1'b1, E_FETCH_RDY}, {OP_ADDI, 1'b1, E_DECODE},
          {OP_ADDI, 1'b1, E_ADDI_EXEC}, {OP_ADDI, 1'b1, E_ADDI_WB}};
    for (int i = 0; i < 4; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL addi[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    vec_t v [3];
    v = '{{OP_BEQ, 1'b1, E_FETCH_RDY}, {OP_BEQ, 1'b1, E_DECODE}, {OP_J, 1'b0, E_BRANCH}};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL branch[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal();
    vec_t v [3];
    v = '{{OP_BAD, 1'b1, E_FETCH_RDY}, {OP_BAD, 1'b1, E_DECODE_ILL}, {OP_BAD, 1'b0, E_FETCH_WAIT}};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL illegal[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_fetch_wait();
    vec_t v [7];
    v = '{{OP_J, 1'b0, E_FETCH_WAIT}, {OP_J, 1'b0, E_FETCH_WAIT}, {OP_J, 1'b0, E_FETCH_WAIT},
          {OP_J, 1'b0, E_FETCH_WAIT}, {OP_J, 1'b1, E_FETCH_RDY}, {OP_J, 1'b0, E_DECODE},
          {OP_J, 1'b0, E_JUMP}};
    for (int i = 0; i < 7; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL fetch_wait[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mem_write();
    vec_t v [5];
    v = '{{OP_SW, 1'b1, E_FETCH_RDY}, {OP_SW, 1'b1, E_DECODE}, {OP_SW, 1'b0, E_MEM_ADDR},
          {OP_SW, 1'b0, E_MEM_WRITE}, {OP_SW, 1'b0, E_MEM_WRITE}};
    for (int i = 0; i < 5; i++) begin
      bus.opcode = v[i].op; bus.mem_ready = v[i].rdy; #1;
      checks++;
      if (obs !== v[i].exp) begin
        errors++;
        $display("FAIL sw_wait[%0d] got %b expected %b", i, obs, v[i].exp);
      end
      next_cycle();
    end
    // Still waiting in MEM_WRITE; reset must clear outputs without a clock edge
    reset = 1'b1; #1;
    checks++;
    if (obs !== E_ZERO) begin
      errors++;
      $display("FAIL reset_async got %b expected %b", obs, E_ZERO);
    end
    next_cycle();
    bus.mem_ready = 1'b1; #1;
    checks++;
    if (obs !== E_ZERO) begin
      errors++;
      $display("FAIL reset_held got %b expected %b", obs, E_ZERO);
    end
    next_cycle();
    reset = 1'b0; bus.mem_ready = 1'b0; #1;
    checks++;
    if (obs !== E_FETCH_WAIT) begin
      errors++;
      $display("FAIL reset_release got %b expected %b", obs, E_FETCH_WAIT);
    end
    next_cycle();
    bus.opcode = OP_ADDI; bus.mem_ready = 1'b1; #1;
    checks++;
    if (obs !== E_FETCH_RDY) begin
      errors++;
      $display("FAIL post_reset_fetch got %b expected %b", obs, E_FETCH_RDY);
    end
    next_cycle();
    #1;
    checks++;
    if (obs !== E_DECODE) begin
      errors++;
      $display("FAIL post_reset_decode got %b expected %b", obs, E_DECODE);
    end
    next_cycle();
    #1;
    checks++;
    if (obs !== E_ADDI_EXEC) begin
      errors++;
      $display("FAIL post_reset_exec got %b expected %b", obs, E_ADDI_EXEC);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b0;
    test_reset();
    test_jump();
    test_lw_wait();
    test_sw();
    test_rtype();
    test_addi();
    test_branch();
    test_illegal();
    test_fetch_wait();
    test_reset_mem_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
